// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants for the request-capture stage and its priority encoder
package irq_pkg;

  localparam int IRQ_WIDTH       = 16;
  localparam int IRQ_IDX_W       = 4;
  localparam int IRQ_SYNC_STAGES = 2;

  // Encoder output when nothing is pending; never a legal ack target.
  localparam logic [7:0] ENC_NONE = 8'hF0;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - one request line: synchroniser, history flop and registered rise strobe
module irq_sync_edge
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = IRQ_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // rise is registered beside prev so the edge and level paths reach the
  // pending register on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign lvl  = prev_q;
  assign rise = rise_q;

endmodule

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - sticky/level request capture feeding the priority encoder; IRQ_PEND_OVERFLOW_EN builds overflow flags
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int WIDTH       = IRQ_WIDTH,
  parameter int SYNC_STAGES = IRQ_SYNC_STAGES,
  parameter int IDX_W       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] edge_mode,
  input  logic [WIDTH-1:0] mask,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_index,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] pend_out,
  output logic             any_pend,
  output logic [WIDTH-1:0] ovf
);

  logic [WIDTH-1:0] lvl;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pend_nxt;
  logic [WIDTH-1:0] ack_hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .req (req_in[i]),
      .lvl (lvl[i]),
      .rise(rise[i])
    );
  end

  // Out-of-range indices shift past the top bit and decode to nothing.
  assign ack_hit = ack_valid ? (WIDTH'(1) << ack_index) : '0;

  // A new rise beats a same-cycle ack; level lines simply follow.
  always_comb begin
    pend_nxt = (edge_mode & (rise | (pending & ~ack_hit))) | (~edge_mode & lvl);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pend_nxt;
    end
  end

  assign pend_out = pending & ~mask;
  assign any_pend = |pend_out;

`ifdef IRQ_PEND_OVERFLOW_EN
  logic [WIDTH-1:0] ovf_q;
  logic [WIDTH-1:0] ovf_set;

  assign ovf_set = edge_mode & rise & pending & ~ack_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (ovf_clr) begin
      ovf_q <= ovf_set;
    end else begin
      ovf_q <= ovf_q | ovf_set;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = '0;
`endif

endmodule
